// File: rtl/retire_trace_fifo.sv
// Retirement-trace capture FIFO: stamps each retired instruction with a sequence
// number and queues it for a valid/ready consumer; overflow drops are counted.
module retire_trace_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int SEQW  = 32
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic                     update_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic [XLEN-1:0]          mem_addr_i,
  input  logic [XLEN-1:0]          mem_data_i,
  input  logic                     mem_wrt_i,
  input  logic                     mem_read_i,
  output logic                     trc_valid_o,
  input  logic                     trc_ready_i,
  output logic [SEQW-1:0]          trc_seq_o,
  output logic [XLEN-1:0]          trc_pc_o,
  output logic [XLEN-1:0]          trc_instr_o,
  output logic [4:0]               trc_rd_addr_o,
  output logic [XLEN-1:0]          trc_rd_data_o,
  output logic [XLEN-1:0]          trc_mem_addr_o,
  output logic [XLEN-1:0]          trc_mem_data_o,
  output logic                     trc_mem_wrt_o,
  output logic                     trc_mem_read_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [SEQW-1:0] seq;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            mem_wrt;
    logic            mem_read;
  } rec_t;

  rec_t            mem [DEPTH];
  rec_t            head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [SEQW-1:0] seq;
  logic [15:0]     drop_cnt;
  logic            overflow;
  logic            cap, pop, full, wr, drop;

  assign full = (count == FULL_CNT);
  assign cap  = update_i & enable_i & ~clear_i;
  assign pop  = trc_valid_o & trc_ready_i & ~clear_i;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr   = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  always_ff @(posedge clk_i) begin
    if (wr)
      mem[wr_ptr] <= '{seq: seq, pc: pc_i, instr: instr_i, rd_addr: reg_addr_i,
                       rd_data: reg_data_i, mem_addr: mem_addr_i, mem_data: mem_data_i,
                       mem_wrt: mem_wrt_i, mem_read: mem_read_i};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (clear_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      // Sequence advances on every capture, dropped or not, so gaps stay visible.
      if (cap) seq <= seq + 1'b1;
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !pop)      count <= count + 1'b1;
      else if (pop && !wr) count <= count - 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  assign head           = mem[rd_ptr];
  assign trc_valid_o    = (count != '0);
  assign trc_seq_o      = head.seq;
  assign trc_pc_o       = head.pc;
  assign trc_instr_o    = head.instr;
  assign trc_rd_addr_o  = head.rd_addr;
  assign trc_rd_data_o  = head.rd_data;
  assign trc_mem_addr_o = head.mem_addr;
  assign trc_mem_data_o = head.mem_data;
  assign trc_mem_wrt_o  = head.mem_wrt;
  assign trc_mem_read_o = head.mem_read;
  assign count_o        = count;
  assign overflow_o     = overflow;
  assign drop_cnt_o     = drop_cnt;
endmodule

// File: tb/tb_retire_trace_fifo.sv
// Directed bench for retire_trace_fifo: ordering, overflow, full write+pop,
// clear priority, streaming across pointer wrap, disable and async reset.
module tb_retire_trace_fifo;
  logic        clk_i = 1'b0, rstn_i = 1'b0;
  logic        enable_i = 1'b0, clear_i = 1'b0, update_i = 1'b0, trc_ready_i = 1'b0;
  logic [31:0] pc_i = '0, instr_i = '0, reg_data_i = '0, mem_addr_i = '0, mem_data_i = '0;
  logic [4:0]  reg_addr_i = '0;
  logic        mem_wrt_i = 1'b0, mem_read_i = 1'b0;
  logic        trc_valid_o, trc_mem_wrt_o, trc_mem_read_o, overflow_o;
  logic [31:0] trc_seq_o, trc_pc_o, trc_instr_o, trc_rd_data_o, trc_mem_addr_o, trc_mem_data_o;
  logic [4:0]  trc_rd_addr_o, count_o;
  logic [15:0] drop_cnt_o;
  int total = 0, bad = 0;

  retire_trace_fifo #(.XLEN(32), .DEPTH(16), .SEQW(32)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i), .clear_i(clear_i),
    .update_i(update_i), .pc_i(pc_i), .instr_i(instr_i), .reg_addr_i(reg_addr_i),
    .reg_data_i(reg_data_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .mem_wrt_i(mem_wrt_i), .mem_read_i(mem_read_i), .trc_valid_o(trc_valid_o),
    .trc_ready_i(trc_ready_i), .trc_seq_o(trc_seq_o), .trc_pc_o(trc_pc_o),
    .trc_instr_o(trc_instr_o), .trc_rd_addr_o(trc_rd_addr_o), .trc_rd_data_o(trc_rd_data_o),
    .trc_mem_addr_o(trc_mem_addr_o), .trc_mem_data_o(trc_mem_data_o),
    .trc_mem_wrt_o(trc_mem_wrt_o), .trc_mem_read_o(trc_mem_read_o),
    .count_o(count_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk_i); #1;
  endtask

  // Present a retire whose payload is derived from pc, held for the next edge.
  task automatic set_retire(input logic [31:0] pc);
    update_i = 1'b1; pc_i = pc; instr_i = ~pc; reg_addr_i = pc[6:2];
    reg_data_i = pc + 32'd1; mem_addr_i = pc ^ 32'h8000_0000; mem_data_i = pc + 32'h1000;
    mem_wrt_i = pc[2]; mem_read_i = pc[3];
  endtask

  task automatic retire(input logic [31:0] pc);
    set_retire(pc); step(); update_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1; step(); clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; #12; rstn_i = 1'b1; step();
    total++; if (trc_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", trc_valid_o); end
    total++; if (count_o !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    total++; if (overflow_o !== 1'b0 || drop_cnt_o !== 16'd0) begin bad++;
      $display("FAIL reset_drop got ovf=%0b drop=%0d exp 0/0", overflow_o, drop_cnt_o); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_pc;
    enable_i = 1'b1; trc_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) retire(32'(i*4));
    total++; if (count_o !== 5'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", count_o); end
    total++; if (trc_valid_o !== 1'b1 || trc_pc_o !== 32'h0 || trc_seq_o !== 32'd0) begin bad++;
      $display("FAIL basic_head got v=%0b pc=%h seq=%0d exp v=1 pc=0 seq=0", trc_valid_o, trc_pc_o, trc_seq_o); end
    trc_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'(i*4);
      total++; if (trc_valid_o !== 1'b1 || trc_pc_o !== exp_pc || trc_seq_o !== 32'(i)) begin bad++;
        $display("FAIL basic_pop%0d got v=%0b pc=%h seq=%0d exp pc=%h seq=%0d", i, trc_valid_o, trc_pc_o, trc_seq_o, exp_pc, i); end
      step();
    end
    trc_ready_i = 1'b0;
    total++; if (trc_valid_o !== 1'b0) begin bad++; $display("FAIL basic_empty got valid=%0b exp=0", trc_valid_o); end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 20; i++) retire(32'(i*4));
    total++; if (count_o !== 5'd16 || drop_cnt_o !== 16'd4 || overflow_o !== 1'b1) begin bad++;
      $display("FAIL ovf_state got cnt=%0d drop=%0d ovf=%0b exp 16/4/1", count_o, drop_cnt_o, overflow_o); end
    trc_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (trc_valid_o !== 1'b1 || trc_seq_o !== 32'(i) || trc_pc_o !== 32'(i*4)) begin bad++;
        $display("FAIL ovf_drain%0d got seq=%0d pc=%h exp seq=%0d", i, trc_seq_o, trc_pc_o, i); end
      step();
    end
    trc_ready_i = 1'b0;
    total++; if (trc_valid_o !== 1'b0) begin bad++; $display("FAIL ovf_empty got valid=%0b exp=0", trc_valid_o); end
    retire(32'h500);
    total++; if (trc_seq_o !== 32'd20 || trc_pc_o !== 32'h500 || count_o !== 5'd1) begin bad++;
      $display("FAIL ovf_next got seq=%0d pc=%h cnt=%0d exp seq=20 pc=500 cnt=1", trc_seq_o, trc_pc_o, count_o); end
    total++; if (drop_cnt_o !== 16'd4 || overflow_o !== 1'b1) begin bad++;
      $display("FAIL ovf_sticky got drop=%0d ovf=%0b exp 4/1", drop_cnt_o, overflow_o); end
  endtask

  task automatic test_full_wr_pop();
    do_clear();
    for (int i = 0; i < 16; i++) retire(32'h100 + 32'(i*4));
    set_retire(32'h200); trc_ready_i = 1'b1; step(); update_i = 1'b0;
    total++; if (count_o !== 5'd16 || drop_cnt_o !== 16'd0 || overflow_o !== 1'b0) begin bad++;
      $display("FAIL fullwp_state got cnt=%0d drop=%0d ovf=%0b exp 16/0/0", count_o, drop_cnt_o, overflow_o); end
    for (int i = 0; i < 15; i++) begin
      total++; if (trc_seq_o !== 32'(i+1) || trc_pc_o !== 32'h100 + 32'((i+1)*4)) begin bad++;
        $display("FAIL fullwp_drain%0d got seq=%0d pc=%h exp seq=%0d", i, trc_seq_o, trc_pc_o, i+1); end
      step();
    end
    total++; if (trc_valid_o !== 1'b1 || trc_pc_o !== 32'h200 || trc_seq_o !== 32'd16) begin bad++;
      $display("FAIL fullwp_last got v=%0b pc=%h seq=%0d exp v=1 pc=200 seq=16", trc_valid_o, trc_pc_o, trc_seq_o); end
    step(); trc_ready_i = 1'b0;
    total++; if (count_o !== 5'd0) begin bad++; $display("FAIL fullwp_empty got cnt=%0d exp=0", count_o); end
  endtask

  task automatic test_clear();
    do_clear();
    for (int i = 0; i < 18; i++) retire(32'(i*4));
    trc_ready_i = 1'b1; repeat (11) step(); trc_ready_i = 1'b0;
    total++; if (count_o !== 5'd5 || drop_cnt_o !== 16'd2) begin bad++;
      $display("FAIL clr_pre got cnt=%0d drop=%0d exp 5/2", count_o, drop_cnt_o); end
    set_retire(32'h700); trc_ready_i = 1'b1; clear_i = 1'b1; step();
    update_i = 1'b0; trc_ready_i = 1'b0; clear_i = 1'b0;
    total++; if (count_o !== 5'd0 || trc_valid_o !== 1'b0 || overflow_o !== 1'b0 || drop_cnt_o !== 16'd0) begin bad++;
      $display("FAIL clr_state got cnt=%0d v=%0b ovf=%0b drop=%0d exp all 0", count_o, trc_valid_o, overflow_o, drop_cnt_o); end
    retire(32'h740);
    total++; if (trc_seq_o !== 32'd0 || trc_pc_o !== 32'h740 || count_o !== 5'd1) begin bad++;
      $display("FAIL clr_next got seq=%0d pc=%h cnt=%0d exp seq=0 pc=740 cnt=1", trc_seq_o, trc_pc_o, count_o); end
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    do_clear(); trc_ready_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      pc = 32'h1000 + 32'(i*4);
      set_retire(pc); step();
      total++;
      if (trc_valid_o !== 1'b1 || count_o > 5'd1 || trc_seq_o !== 32'(i) || trc_pc_o !== pc ||
          trc_instr_o !== ~pc || trc_rd_addr_o !== pc[6:2] || trc_rd_data_o !== pc + 32'd1 ||
          trc_mem_addr_o !== (pc ^ 32'h8000_0000) || trc_mem_data_o !== pc + 32'h1000 ||
          trc_mem_wrt_o !== pc[2] || trc_mem_read_o !== pc[3]) begin
        bad++;
        $display("FAIL stream%0d got v=%0b cnt=%0d seq=%0d pc=%h instr=%h exp seq=%0d pc=%h", i,
                 trc_valid_o, count_o, trc_seq_o, trc_pc_o, trc_instr_o, i, pc);
      end
    end
    update_i = 1'b0; step(); trc_ready_i = 1'b0;
    total++; if (count_o !== 5'd0 || drop_cnt_o !== 16'd0 || overflow_o !== 1'b0) begin bad++;
      $display("FAIL stream_end got cnt=%0d drop=%0d ovf=%0b exp 0/0/0", count_o, drop_cnt_o, overflow_o); end
  endtask

  task automatic test_disable_reset();
    do_clear(); enable_i = 1'b0;
    for (int i = 0; i < 3; i++) retire(32'h2000 + 32'(i*4));
    total++; if (count_o !== 5'd0 || trc_valid_o !== 1'b0) begin bad++;
      $display("FAIL dis_nocap got cnt=%0d v=%0b exp 0/0", count_o, trc_valid_o); end
    enable_i = 1'b1;
    retire(32'h3000);
    total++; if (trc_seq_o !== 32'd0 || trc_pc_o !== 32'h3000) begin bad++;
      $display("FAIL dis_seq got seq=%0d pc=%h exp seq=0 pc=3000", trc_seq_o, trc_pc_o); end
    for (int i = 0; i < 6; i++) retire(32'h3004 + 32'(i*4));
    total++; if (count_o !== 5'd7) begin bad++; $display("FAIL rst_pre got cnt=%0d exp=7", count_o); end
    #2; rstn_i = 1'b0; #1;
    total++; if (trc_valid_o !== 1'b0 || count_o !== 5'd0) begin bad++;
      $display("FAIL rst_async got v=%0b cnt=%0d exp 0/0", trc_valid_o, count_o); end
    #2; rstn_i = 1'b1; step();
    retire(32'h4000);
    total++; if (trc_seq_o !== 32'd0 || count_o !== 5'd1) begin bad++;
      $display("FAIL rst_seq got seq=%0d cnt=%0d exp 0/1", trc_seq_o, count_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_wr_pop();
    test_clear();
    test_stream();
    test_disable_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
